// File: rtl/emu_host_transactor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : emu_host_transactor_if
// Brief    : Host byte streams plus emulator byte bus between transactor and wrapper.
// Revision : 1.0
// ============================================================================
interface emu_host_transactor_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] Din_emu;
   logic [2:0] Addr_emu;
   logic       load_emu;
   logic       get_emu;
   logic [7:0] Dout_emu;

   modport master (
      input  s_data, s_valid, m_ready, Dout_emu,
      output s_ready, m_data, m_valid, Din_emu, Addr_emu, load_emu, get_emu
   );

   modport slave (
      output s_data, s_valid, m_ready, Dout_emu,
      input  s_ready, m_data, m_valid, Din_emu, Addr_emu, load_emu, get_emu
   );
endinterface
`default_nettype wire

// File: rtl/emu_host_transactor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : emu_host_transactor
// Brief    : Host-side master for the emulator byte bus: frame in, load, get, frame out.
// Revision : 1.0
// ============================================================================
module emu_host_transactor #(
   parameter int NUM_STIM_ARRAY = 1,
   parameter int NUM_OUT_ARRAY  = 3,
   parameter int WAIT_CYC       = 4
) (
   input  logic                  clk_emu,
   input  logic                  rst_emu_n,
   emu_host_transactor_if.master bus,
   output logic                  busy,
   output logic [15:0]           frame_cnt
);
   localparam logic [2:0] STIM_LAST = 3'(NUM_STIM_ARRAY - 1);
   localparam logic [2:0] OUT_LAST  = 3'(NUM_OUT_ARRAY - 1);
   localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYC);
   localparam logic [3:0] STIM_SIZE = 4'(NUM_STIM_ARRAY);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_RX   = 4'd1,
      S_WR   = 4'd2,
      S_LOAD = 4'd3,
      S_WAIT = 4'd4,
      S_GET  = 4'd5,
      S_RSET = 4'd6,
      S_RSMP = 4'd7,
      S_TX   = 4'd8
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic       armed;
   logic [2:0] idx_i;
   logic [2:0] idx_j;
   logic [7:0] wait_cnt;
   logic [7:0] shadow [8];
   logic [7:0] out_data;
   logic       out_valid;
   logic       s_ready_c;
   logic       load_c;
   logic       get_c;
   logic [2:0] addr_c;
   logic       accept;

   always_ff @(posedge clk_emu or negedge rst_emu_n) begin
      if (!rst_emu_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      s_ready_c = 1'b0;
      load_c    = 1'b0;
      get_c     = 1'b0;
      addr_c    = 3'd0;
      case (state)
         S_IDLE: begin
            // armed keeps s_ready low while reset is asserted and for the release cycle
            s_ready_c = armed;
            if (armed && bus.s_valid) begin
               if (NUM_STIM_ARRAY > 1) state_nx = S_RX;
               else                    state_nx = S_WR;
            end
         end
         S_RX: begin
            s_ready_c = 1'b1;
            if (bus.s_valid && idx_i == STIM_LAST) state_nx = S_WR;
         end
         S_WR: begin
            addr_c = idx_i;
            if (idx_i == STIM_LAST) state_nx = S_LOAD;
         end
         S_LOAD: begin
            load_c = 1'b1;
            if (WAIT_CYC == 0) state_nx = S_GET;
            else               state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt <= 8'd1) state_nx = S_GET;
         end
         S_GET: begin
            get_c    = 1'b1;
            state_nx = S_RSET;
         end
         S_RSET: begin
            addr_c   = idx_j;
            state_nx = S_RSMP;
         end
         S_RSMP: begin
            addr_c   = idx_j;
            state_nx = S_TX;
         end
         S_TX: begin
            addr_c = idx_j;
            if (bus.m_ready) begin
               if (idx_j == OUT_LAST) state_nx = S_IDLE;
               else                   state_nx = S_RSET;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign accept = s_ready_c & bus.s_valid;

   always_ff @(posedge clk_emu or negedge rst_emu_n) begin
      if (!rst_emu_n) begin
         armed     <= 1'b0;
         idx_i     <= 3'd0;
         idx_j     <= 3'd0;
         wait_cnt  <= 8'd0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         frame_cnt <= 16'd0;
         for (int k = 0; k < 8; k++) shadow[k] <= 8'd0;
      end else begin
         armed <= 1'b1;
         case (state)
            S_IDLE, S_RX: begin
               if (accept) begin
                  // entries at or above NUM_STIM_ARRAY are never written and stay zero
                  for (int k = 0; k < NUM_STIM_ARRAY; k++) begin
                     if (idx_i == 3'(k)) shadow[k] <= bus.s_data;
                  end
                  idx_i <= (idx_i == STIM_LAST) ? 3'd0 : idx_i + 3'd1;
               end
            end
            S_WR:   idx_i    <= (idx_i == STIM_LAST) ? 3'd0 : idx_i + 3'd1;
            S_LOAD: wait_cnt <= WAIT_INIT;
            S_WAIT: wait_cnt <= wait_cnt - 8'd1;
            S_GET:  idx_j    <= 3'd0;
            S_RSMP: begin
               out_data  <= bus.Dout_emu;
               out_valid <= 1'b1;
            end
            S_TX: begin
               if (bus.m_ready) begin
                  out_valid <= 1'b0;
                  if (idx_j != OUT_LAST) idx_j     <= idx_j + 3'd1;
                  else                   frame_cnt <= frame_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // The wrapper latches Din_emu into stimIn[Addr_emu] on every idle bus cycle
   assign bus.Din_emu  = ({1'b0, addr_c} < STIM_SIZE) ? shadow[addr_c] : 8'd0;
   assign bus.Addr_emu = addr_c;
   assign bus.load_emu = load_c;
   assign bus.get_emu  = get_c;
   assign bus.s_ready  = s_ready_c;
   assign bus.m_data   = out_data;
   assign bus.m_valid  = out_valid;
   assign busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_emu_host_transactor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_emu_host_transactor
// Brief    : Self-checking bench: default instance (A) and 3-byte, zero-wait instance (B).
// Revision : 1.0
// ============================================================================
module tb_emu_host_transactor;
   localparam int BOUND = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy_a, busy_b;
   logic [15:0] fc_a, fc_b;
   int          checks = 0;
   int          errors = 0;

   emu_host_transactor_if ba();
   emu_host_transactor_if bb();

   emu_host_transactor u_a (
      .clk_emu(clk), .rst_emu_n(rst_n), .bus(ba.master), .busy(busy_a), .frame_cnt(fc_a)
   );
   emu_host_transactor #(.NUM_STIM_ARRAY(3), .NUM_OUT_ARRAY(3), .WAIT_CYC(0)) u_b (
      .clk_emu(clk), .rst_emu_n(rst_n), .bus(bb.master), .busy(busy_b), .frame_cnt(fc_b)
   );

   always #5 clk = ~clk;

   // Wrapper behaviour: captured byte k = key[k] + s0 + 2*s1 + 4*s2 (mod 256)
   function automatic logic [7:0] model_out(input int k, input logic [7:0] s0, s1, s2);
      logic [7:0] key;
      case (k)
         0:       key = 8'h07;
         1:       key = 8'h29;
         default: key = 8'h4B;
      endcase
      return key + s0 + {s1[6:0], 1'b0} + {s2[5:0], 2'b00};
   endfunction

   logic [7:0] stim_a [8], app_a [8], cap_a [8];
   logic [7:0] stim_b [8], app_b [8], cap_b [8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            stim_a[k] <= 8'd0; app_a[k] <= 8'd0; cap_a[k] <= 8'd0;
            stim_b[k] <= 8'd0; app_b[k] <= 8'd0; cap_b[k] <= 8'd0;
         end
         ba.Dout_emu <= 8'd0;
         bb.Dout_emu <= 8'd0;
      end else begin
         if (!ba.load_emu && !ba.get_emu) stim_a[ba.Addr_emu] <= ba.Din_emu;
         if (ba.load_emu) app_a <= stim_a;
         if (ba.get_emu) for (int k = 0; k < 3; k++) cap_a[k] <= model_out(k, app_a[0], 8'd0, 8'd0);
         ba.Dout_emu <= cap_a[ba.Addr_emu];
         if (!bb.load_emu && !bb.get_emu) stim_b[bb.Addr_emu] <= bb.Din_emu;
         if (bb.load_emu) app_b <= stim_b;
         if (bb.get_emu) for (int k = 0; k < 3; k++) cap_b[k] <= model_out(k, app_b[0], app_b[1], app_b[2]);
         bb.Dout_emu <= cap_b[bb.Addr_emu];
      end
   end

   // Pulse monitor: counts, cycle stamps and the bus history preceding each load
   int         cyc = 0, n_load_a = 0, n_get_a = 0, load_cyc_a = 0, get_cyc_a = 0;
   int         n_load_b = 0, n_get_b = 0, load_cyc_b = 0, get_cyc_b = 0, both_err = 0;
   logic [2:0] ha_addr, wr_addr_a, hb_addr [3], wr_addr_b [3];
   logic [7:0] ha_din, wr_din_a, hb_din [3], wr_din_b [3];

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      ha_addr    <= ba.Addr_emu;
      ha_din     <= ba.Din_emu;
      hb_addr[0] <= bb.Addr_emu; hb_addr[1] <= hb_addr[0]; hb_addr[2] <= hb_addr[1];
      hb_din[0]  <= bb.Din_emu;  hb_din[1]  <= hb_din[0];  hb_din[2]  <= hb_din[1];
      if (ba.load_emu) begin
         n_load_a <= n_load_a + 1; load_cyc_a <= cyc; wr_addr_a <= ha_addr; wr_din_a <= ha_din;
      end
      if (ba.get_emu) begin n_get_a <= n_get_a + 1; get_cyc_a <= cyc; end
      if (bb.load_emu) begin
         n_load_b <= n_load_b + 1; load_cyc_b <= cyc; wr_addr_b <= hb_addr; wr_din_b <= hb_din;
      end
      if (bb.get_emu) begin n_get_b <= n_get_b + 1; get_cyc_b <= cyc; end
      if ((ba.load_emu && ba.get_emu) || (bb.load_emu && bb.get_emu)) both_err <= both_err + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input bit inst, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      if (inst) begin bb.s_data = d; bb.s_valid = 1'b1; end
      else      begin ba.s_data = d; ba.s_valid = 1'b1; end
      while (!(inst ? bb.s_ready : ba.s_ready) && n < BOUND) begin @(negedge clk); n++; end
      chk("send_handshake", int'(n < BOUND), 1);
      @(posedge clk); #1;
      if (inst) bb.s_valid = 1'b0; else ba.s_valid = 1'b0;
   endtask

   task automatic recv(input bit inst, input logic [7:0] exp, input int dly, input string name);
      int n = 0;
      @(negedge clk);
      while (!(inst ? bb.m_valid : ba.m_valid) && n < BOUND) begin @(negedge clk); n++; end
      chk({name, "_valid"}, int'(n < BOUND), 1);
      repeat (dly) @(negedge clk);
      if (inst) bb.m_ready = 1'b1; else ba.m_ready = 1'b1;
      chk(name, int'(inst ? bb.m_data : ba.m_data), int'(exp));
      @(posedge clk); #1;
      if (inst) bb.m_ready = 1'b0; else ba.m_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0] stim;
      logic [7:0] e0, e1, e2;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int n, l0, g0;
      vecs[0] = '{8'h00, 8'h07, 8'h29, 8'h4B};
      vecs[1] = '{8'hFF, 8'h06, 8'h28, 8'h4A};
      vecs[2] = '{8'h80, 8'h87, 8'hA9, 8'hCB};
      vecs[3] = '{8'h30, 8'h37, 8'h59, 8'h7B};
      vecs[4] = '{8'h0B, 8'h12, 8'h34, 8'h56};
      ba.s_data = 8'd0; ba.s_valid = 1'b0; ba.m_ready = 1'b0;
      bb.s_data = 8'd0; bb.s_valid = 1'b0; bb.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", int'(ba.s_ready), 0);
      chk("rst_busy", int'(busy_a), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_s_ready", int'(ba.s_ready), 1);

      // T1: reset asserted mid-WAIT
      l0 = n_load_a;
      send(1'b0, 8'h55);
      n = 0;
      while (n_load_a == l0 && n < BOUND) begin @(negedge clk); n++; end
      chk("t1_load_seen", int'(n < BOUND), 1);
      @(negedge clk);
      chk("t1_in_wait_busy", int'(busy_a), 1);
      rst_n = 1'b0;
      #1;
      chk("t1_busy", int'(busy_a), 0);
      chk("t1_s_ready", int'(ba.s_ready), 0);
      chk("t1_m_valid", int'(ba.m_valid), 0);
      chk("t1_m_data", int'(ba.m_data), 0);
      chk("t1_din", int'(ba.Din_emu), 0);
      chk("t1_addr", int'(ba.Addr_emu), 0);
      chk("t1_load_get", int'({ba.load_emu, ba.get_emu}), 0);
      chk("t1_frame_cnt", int'(fc_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t1_s_ready_after", int'(ba.s_ready), 1);
      chk("t1_busy_after", int'(busy_a), 0);

      // T2/T3/T4: single frame 0x0B with read-phase and back-pressure checks
      l0 = n_load_a; g0 = n_get_a;
      send(1'b0, 8'h0B);
      n = 0;
      while (n_get_a == g0 && n < BOUND) begin @(negedge clk); n++; end
      chk("t2_get_seen", int'(n < BOUND), 1);
      chk("t2_wr_addr", int'(wr_addr_a), 0);
      chk("t2_wr_din", int'(wr_din_a), 'h0B);
      chk("t2_load_to_get", get_cyc_a - load_cyc_a, 5);
      for (int c = 0; c < 3; c++) begin
         chk("t3_addr", int'(ba.Addr_emu), 0);
         chk("t3_din", int'(ba.Din_emu), 'h0B);
         @(negedge clk);
      end
      recv(1'b0, 8'h12, 0, "t2_byte0");
      n = 0;
      while (!ba.m_valid && n < BOUND) begin @(negedge clk); n++; end
      chk("t4_valid_seen", int'(n < BOUND), 1);
      for (int c = 0; c < 10; c++) begin
         chk("t4_m_valid", int'(ba.m_valid), 1);
         chk("t4_m_data", int'(ba.m_data), 'h34);
         chk("t4_s_ready", int'(ba.s_ready), 0);
         @(negedge clk);
      end
      recv(1'b0, 8'h34, 0, "t2_byte1");
      recv(1'b0, 8'h56, 0, "t2_byte2");
      chk("t3_stim_kept", int'(stim_a[0]), 'h0B);
      chk("t2_one_load", n_load_a - l0, 1);
      chk("t2_one_get", n_get_a - g0, 1);

      // Table-driven frames on instance A
      for (int v = 0; v < 5; v++) begin
         send(1'b0, vecs[v].stim);
         recv(1'b0, vecs[v].e0, v % 3, "vec_byte0");
         recv(1'b0, vecs[v].e1, 0,     "vec_byte1");
         recv(1'b0, vecs[v].e2, 1,     "vec_byte2");
      end
      chk("vec_frame_cnt", int'(fc_a), 6);

      // T5: three stimulus bytes, zero wait
      send(1'b1, 8'hA1);
      send(1'b1, 8'hA2);
      send(1'b1, 8'hA3);
      recv(1'b1, 8'h78, 0, "t5_byte0");
      recv(1'b1, 8'h9A, 0, "t5_byte1");
      recv(1'b1, 8'hBC, 0, "t5_byte2");
      chk("t5_wr_addr0", int'(wr_addr_b[2]), 0);
      chk("t5_wr_addr1", int'(wr_addr_b[1]), 1);
      chk("t5_wr_addr2", int'(wr_addr_b[0]), 2);
      chk("t5_wr_din0", int'(wr_din_b[2]), 'hA1);
      chk("t5_wr_din1", int'(wr_din_b[1]), 'hA2);
      chk("t5_wr_din2", int'(wr_din_b[0]), 'hA3);
      chk("t5_load_to_get", get_cyc_b - load_cyc_b, 1);
      chk("t5_frame_cnt", int'(fc_b), 1);

      // T6: 100 back-to-back frames with random host stalls
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      fork
         begin
            for (int f = 0; f < 100; f++) send(1'b0, 8'(f * 37 + 5));
         end
         begin
            for (int f = 0; f < 100; f++) begin
               for (int k = 0; k < 3; k++) begin
                  recv(1'b0, model_out(k, 8'(f * 37 + 5), 8'd0, 8'd0),
                       int'($urandom_range(0, 3)), "t6_byte");
               end
            end
         end
      join
      repeat (2) @(negedge clk);
      chk("t6_frame_cnt", int'(fc_a), 100);
      chk("t6_idle", int'(busy_a), 0);
      chk("load_get_exclusive", both_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
